// File: rtl/dmem_arbiter_if.sv
// Requester and DMEM signal bundle for dmem_arbiter.
// The arbiter takes the slave modport. The requesters and the DMEM model take the master modport.
interface dmem_arbiter_if;
  logic        p0_req;
  logic        p0_we;
  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic [1:0]  p0_size;
  logic        p0_ack;
  logic        p0_err;
  logic [31:0] p0_rdata;

  logic        p1_req;
  logic        p1_we;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic [1:0]  p1_size;
  logic        p1_ack;
  logic        p1_err;
  logic [31:0] p1_rdata;

  logic [31:0] daddr;
  logic [31:0] indata;
  logic [1:0]  str;
  logic [1:0]  stw;
  logic        we;
  logic [31:0] outdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata, p0_size,
    output p0_ack, p0_err, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata, p1_size,
    output p1_ack, p1_err, p1_rdata,
    output daddr, indata, str, stw, we,
    input  outdata
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata, p0_size,
    input  p0_ack, p0_err, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata, p1_size,
    input  p1_ack, p1_err, p1_rdata,
    input  daddr, indata, str, stw, we,
    output outdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port DMEM access controller: IDLE -> ISSUE -> DONE, one access per 3 cycles.
// Define DMEM_ARB_RR_EN for round-robin arbitration. Without it, port 0 has fixed priority.
// Handshake: a requester holds req high until its one-cycle ack. err and rdata are valid with ack,
// and rdata holds its value until the next ack on the same port.
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dmem_arbiter_if.slave        bus,
  output logic                 busy,
  output logic [1:0]           dbg_state_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_t;

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  state_t      state_q, state_d;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic        we_q, port_q, err_q;
  logic [31:0] p0_rdata_q, p1_rdata_q;

  logic        any_req, grant_p1;
  logic [31:0] sel_addr, sel_wdata;
  logic [1:0]  sel_size;
  logic        sel_we, sel_err;
  logic        issue_ok, done, good_rd;

`ifdef DMEM_ARB_RR_EN
  logic last_q;  // 1 = port 1 was served last
`endif

  always_comb begin
    any_req = bus.p0_req | bus.p1_req;
`ifdef DMEM_ARB_RR_EN
    if (bus.p0_req && bus.p1_req) grant_p1 = ~last_q;
    else                          grant_p1 = bus.p1_req;
`else
    grant_p1 = bus.p1_req & ~bus.p0_req;
`endif
    sel_addr  = grant_p1 ? bus.p1_addr  : bus.p0_addr;
    sel_wdata = grant_p1 ? bus.p1_wdata : bus.p0_wdata;
    sel_size  = grant_p1 ? bus.p1_size  : bus.p0_size;
    sel_we    = grant_p1 ? bus.p1_we    : bus.p0_we;
    sel_err   = (sel_size == 2'b11) ||
                (sel_size == 2'b01 && sel_addr[0]) ||
                (sel_size == 2'b10 && sel_addr[1:0] != 2'b00) ||
                (sel_addr >= MEM_LIMIT);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      we_q       <= 1'b0;
      port_q     <= 1'b0;
      err_q      <= 1'b0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
`ifdef DMEM_ARB_RR_EN
      last_q     <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_req) begin
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        size_q  <= sel_size;
        we_q    <= sel_we;
        port_q  <= grant_p1;
        err_q   <= sel_err;
`ifdef DMEM_ARB_RR_EN
        last_q  <= grant_p1;
`endif
      end
      if (good_rd) begin
        if (port_q) p1_rdata_q <= bus.outdata;
        else        p0_rdata_q <= bus.outdata;
      end
    end
  end

  // All outputs decode from state_q, so an async reset drops we immediately.
  always_comb begin
    issue_ok     = (state_q == ISSUE) && !err_q;
    done         = (state_q == DONE);
    good_rd      = done && !err_q && !we_q;
    bus.daddr    = issue_ok ? addr_q : '0;
    bus.indata   = (issue_ok && we_q) ? wdata_q : '0;
    bus.stw      = (issue_ok && we_q) ? size_q : 2'b00;
    bus.str      = (issue_ok && !we_q) ? size_q : 2'b00;
    bus.we       = issue_ok && we_q;
    bus.p0_ack   = done && !port_q;
    bus.p1_ack   = done && port_q;
    bus.p0_err   = done && !port_q && err_q;
    bus.p1_err   = done && port_q && err_q;
    // The DMEM read data arrives in DONE, so it is forwarded here to line up with the ack.
    bus.p0_rdata = (good_rd && !port_q) ? bus.outdata : p0_rdata_q;
    bus.p1_rdata = (good_rd && port_q)  ? bus.outdata : p1_rdata_q;
    busy         = (state_q != IDLE);
    dbg_state_o  = state_q;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a byte-wide little-endian DMEM model.
// Compile with or without DMEM_ARB_RR_EN. The expected ack order follows the macro.
module tb_dmem_arbiter;
  localparam int MEM_BYTES = 1024;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [1:0] dbg_state;
  int         n_checks;
  int         n_pass;
  logic [0:0] exp_q[$];
  logic [7:0] mem [0:MEM_BYTES-1];

  dmem_arbiter_if bus ();

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // Clock and DMEM model: the read is registered, so data is valid the cycle after daddr.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [1:0] s);
    logic [9:0] i;
    i = a[9:0];
    case (s)
      2'b00:   mem_rd = {24'h0, mem[i]};
      2'b01:   mem_rd = {16'h0, mem[i+10'd1], mem[i]};
      default: mem_rd = {mem[i+10'd3], mem[i+10'd2], mem[i+10'd1], mem[i]};
    endcase
  endfunction

  always @(posedge clk) begin
    if (bus.we) begin
      mem[bus.daddr[9:0]] <= bus.indata[7:0];
      if (bus.stw != 2'b00) mem[bus.daddr[9:0]+10'd1] <= bus.indata[15:8];
      if (bus.stw == 2'b10) begin
        mem[bus.daddr[9:0]+10'd2] <= bus.indata[23:16];
        mem[bus.daddr[9:0]+10'd3] <= bus.indata[31:24];
      end
    end
    bus.outdata <= mem_rd(bus.daddr, bus.str);
  end

  // Driver: one access on one port. lat is the number of negedges from req to ack, or -1 on timeout.
  task automatic access(input bit port, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] s, output int lat, output logic e, output logic [31:0] rd,
                        output logic [31:0] i_daddr, output logic [31:0] i_indata,
                        output logic [1:0] i_stw, output logic [1:0] i_str, output int we_cnt);
    @(negedge clk);
    if (port) begin
      bus.p1_we = w; bus.p1_addr = a; bus.p1_wdata = d; bus.p1_size = s; bus.p1_req = 1'b1;
    end else begin
      bus.p0_we = w; bus.p0_addr = a; bus.p0_wdata = d; bus.p0_size = s; bus.p0_req = 1'b1;
    end
    lat = -1; e = 1'b0; rd = '0; we_cnt = 0;
    i_daddr = '0; i_indata = '0; i_stw = '0; i_str = '0;
    for (int c = 1; c <= 8 && lat < 0; c++) begin
      @(negedge clk);
      if (bus.we) we_cnt++;
      if (c == 1) begin
        i_daddr = bus.daddr; i_indata = bus.indata; i_stw = bus.stw; i_str = bus.str;
      end
      if (port ? bus.p1_ack : bus.p0_ack) begin
        lat = c;
        e   = port ? bus.p1_err : bus.p0_err;
        rd  = port ? bus.p1_rdata : bus.p0_rdata;
      end
    end
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({busy, dbg_state, bus.we, bus.p0_ack, bus.p1_ack} !== 6'b0) begin
      $display("FAIL reset_ctrl: got %b want 000000",
               {busy, dbg_state, bus.we, bus.p0_ack, bus.p1_ack});
    end else n_pass++;
    n_checks++;
    if (bus.p0_rdata !== 32'h0 || bus.p1_rdata !== 32'h0) begin
      $display("FAIL reset_rdata: got %h/%h want 0/0", bus.p0_rdata, bus.p1_rdata);
    end else n_pass++;
    n_checks++;
    if (bus.daddr !== 32'h0 || bus.indata !== 32'h0 || bus.str !== 2'b0 || bus.stw !== 2'b0) begin
      $display("FAIL reset_dmem: got daddr=%h indata=%h str=%b stw=%b want zeros",
               bus.daddr, bus.indata, bus.str, bus.stw);
    end else n_pass++;
  endtask

  task automatic test_write_read();
    int lat, wc; logic e; logic [31:0] rd, da, di; logic [1:0] sw, sr;
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, lat, e, rd, da, di, sw, sr, wc);
    n_checks++;
    if (lat !== 2 || e !== 1'b0) begin
      $display("FAIL wr_ack: got lat=%0d err=%b want lat=2 err=0", lat, e);
    end else n_pass++;
    n_checks++;
    if (wc !== 1 || sw !== 2'b10 || da !== 32'h10 || di !== 32'hDEADBEEF) begin
      $display("FAIL wr_issue: got we_cycles=%0d stw=%b daddr=%h indata=%h want 1/10/10/deadbeef",
               wc, sw, da, di);
    end else n_pass++;
    access(1'b0, 1'b0, 32'h10, 32'h0, 2'b10, lat, e, rd, da, di, sw, sr, wc);
    n_checks++;
    if (lat !== 2 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin
      $display("FAIL rd_ack: got lat=%0d err=%b rdata=%h want 2/0/deadbeef", lat, e, rd);
    end else n_pass++;
    n_checks++;
    if (sr !== 2'b10 || da !== 32'h10 || wc !== 0) begin
      $display("FAIL rd_issue: got str=%b daddr=%h we_cycles=%0d want 10/10/0", sr, da, wc);
    end else n_pass++;
  endtask

  task automatic test_errors();
    logic [31:0] addrs [4];
    logic [1:0]  sizes [4];
    logic        wes   [4];
    int lat, wc; logic e; logic [31:0] rd, da, di; logic [1:0] sw, sr;
    addrs = '{32'h2, 32'h1, 32'h0, 32'(MEM_BYTES)};
    sizes = '{2'b10, 2'b01, 2'b11, 2'b10};
    wes   = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      access(1'b0, wes[k], addrs[k], 32'h5555AAAA, sizes[k], lat, e, rd, da, di, sw, sr, wc);
      n_checks++;
      if (lat !== 2 || e !== 1'b1) begin
        $display("FAIL err_ack%0d: got lat=%0d err=%b want 2/1", k, lat, e);
      end else n_pass++;
      n_checks++;
      if (wc !== 0 || da !== 32'h0 || di !== 32'h0 || sw !== 2'b0 || sr !== 2'b0) begin
        $display("FAIL err_quiet%0d: got we_cycles=%0d daddr=%h indata=%h stw=%b str=%b want zeros",
                 k, wc, da, di, sw, sr);
      end else n_pass++;
      n_checks++;
      if (rd !== 32'hDEADBEEF) begin
        $display("FAIL err_rdata%0d: got %h want deadbeef", k, rd);
      end else n_pass++;
    end
  endtask

  task automatic test_port1();
    int lat, wc; logic e; logic [31:0] rd, da, di; logic [1:0] sw, sr;
    access(1'b1, 1'b1, 32'h7, 32'h000000AB, 2'b00, lat, e, rd, da, di, sw, sr, wc);
    n_checks++;
    if (lat !== 2 || e !== 1'b0 || wc !== 1 || sw !== 2'b00 || da !== 32'h7 || di !== 32'hAB) begin
      $display("FAIL p1_wr: got lat=%0d err=%b we_cycles=%0d stw=%b daddr=%h indata=%h want 2/0/1/00/7/ab",
               lat, e, wc, sw, da, di);
    end else n_pass++;
    access(1'b1, 1'b0, 32'h4, 32'h0, 2'b10, lat, e, rd, da, di, sw, sr, wc);
    n_checks++;
    if (lat !== 2 || e !== 1'b0 || sr !== 2'b10 || rd !== 32'hAB000000) begin
      $display("FAIL p1_rd: got lat=%0d err=%b str=%b rdata=%h want 2/0/10/ab000000", lat, e, sr, rd);
    end else n_pass++;
    n_checks++;
    if (bus.p0_rdata !== 32'hDEADBEEF) begin
      $display("FAIL p0_hold: got %h want deadbeef", bus.p0_rdata);
    end else n_pass++;
  endtask

  task automatic test_back_to_back();
    int acks, last_cyc;
    logic [0:0] exp;
    exp_q.delete();
`ifdef DMEM_ARB_RR_EN
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
    @(negedge clk);
    bus.p0_we = 1'b0; bus.p0_addr = 32'h10; bus.p0_size = 2'b10; bus.p0_req = 1'b1;
    bus.p1_we = 1'b0; bus.p1_addr = 32'h10; bus.p1_size = 2'b10; bus.p1_req = 1'b1;
    acks = 0; last_cyc = 0;
    for (int c = 1; c <= 60 && acks < 7; c++) begin
      @(negedge clk);
      if (bus.p0_ack || bus.p1_ack) begin
        exp = exp_q.pop_front();
        n_checks++;
        if (bus.p0_ack === bus.p1_ack || bus.p1_ack !== exp) begin
          $display("FAIL order%0d: got p0_ack=%b p1_ack=%b want port %0d", acks, bus.p0_ack, bus.p1_ack, exp);
        end else n_pass++;
        n_checks++;
        if (c - last_cyc !== (acks == 0 ? 2 : 3)) begin
          $display("FAIL spacing%0d: got %0d cycles want %0d", acks, c - last_cyc, acks == 0 ? 2 : 3);
        end else n_pass++;
        last_cyc = c;
        acks++;
        if (acks >= 6) begin
          if (bus.p0_ack) bus.p0_req = 1'b0;
          else            bus.p1_req = 1'b0;
        end
      end
    end
    n_checks++;
    if (acks !== 7) begin
      $display("FAIL b2b_count: got %0d acks want 7", acks);
    end else n_pass++;
    bus.p0_req = 1'b0; bus.p1_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    int seen, acks;
    @(negedge clk);
    bus.p0_we = 1'b1; bus.p0_addr = 32'h20; bus.p0_wdata = 32'h12345678; bus.p0_size = 2'b10;
    bus.p0_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.we !== 1'b1) begin
      $display("FAIL rst_pre_we: got %b want 1", bus.we);
    end else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.we !== 1'b0 || busy !== 1'b0 || bus.daddr !== 32'h0 || bus.indata !== 32'h0 ||
        bus.stw !== 2'b0 || bus.p0_rdata !== 32'h0 || bus.p1_rdata !== 32'h0) begin
      $display("FAIL rst_async: got we=%b busy=%b daddr=%h indata=%h stw=%b rdata=%h/%h want zeros",
               bus.we, busy, bus.daddr, bus.indata, bus.stw, bus.p0_rdata, bus.p1_rdata);
    end else n_pass++;
    bus.p0_req = 1'b0;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.p0_ack || bus.p1_ack || bus.we) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      $display("FAIL rst_no_ack: got %0d active cycles want 0", seen);
    end else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    bus.p0_we = 1'b0; bus.p0_addr = 32'h10; bus.p0_size = 2'b10; bus.p0_req = 1'b1;
    bus.p1_we = 1'b0; bus.p1_addr = 32'h4;  bus.p1_size = 2'b10; bus.p1_req = 1'b1;
    acks = 0;
    for (int c = 1; c <= 20 && acks < 2; c++) begin
      @(negedge clk);
      if (bus.p0_ack || bus.p1_ack) begin
        n_checks++;
        if (bus.p0_ack !== (acks == 0) || bus.p1_ack !== (acks == 1)) begin
          $display("FAIL rst_tie%0d: got p0_ack=%b p1_ack=%b want port %0d", acks, bus.p0_ack, bus.p1_ack, acks);
        end else n_pass++;
        if (bus.p0_ack) bus.p0_req = 1'b0;
        else            bus.p1_req = 1'b0;
        acks++;
      end
    end
    n_checks++;
    if (acks !== 2) begin
      $display("FAIL rst_tie_count: got %0d acks want 2", acks);
    end else n_pass++;
    bus.p0_req = 1'b0; bus.p1_req = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;
    rst_n = 1'b0;
    bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0; bus.p0_size = '0;
    bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0; bus.p1_size = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_write_read();
    test_errors();
    test_port1();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port access controller for the data memory (DMEM). It arbitrates between two requesters (port 0: CPU load/store unit, port 1: debug/DMA) and sequences one DMEM access at a time by driving `daddr`, `indata`, `str`, `stw` and `we`. It captures `outdata` for reads and returns an ack with data or an error to the winning port. It sits between the requesters and the DMEM instance; DMEM shares `clk`.

## Interface
Parameters:
- `MEM_BYTES`, 1024: DMEM size in bytes. An address at or above this value is out of range.

Ports. One clock; reset is asynchronous and active-low.
- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `p0_req`, `p1_req` in 1: access request; held high until the matching ack.
- `p0_we`, `p1_we` in 1: 1 = write, 0 = read.
- `p0_addr`, `p1_addr` in 32: byte address.
- `p0_wdata`, `p1_wdata` in 32: write data, right-aligned.
- `p0_size`, `p1_size` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `p0_ack`, `p1_ack` out 1: one-cycle completion pulse.
- `p0_err`, `p1_err` out 1: valid with ack; access rejected.
- `p0_rdata`, `p1_rdata` out 32: read data, valid with ack and held until the next ack on that port.
- `daddr` out 32: DMEM address.
- `indata` out 32: DMEM write data.
- `str` out 2: DMEM read size select, same encoding as size.
- `stw` out 2: DMEM write size select.
- `we` out 1: DMEM write enable.
- `outdata` in 32: DMEM read data, valid the cycle after the address is presented.
- `busy` out 1: FSM not in IDLE.

## Operation
- FSM states are IDLE, ISSUE and DONE.
- **IDLE:** if any `req` is high, choose a winner (see Configuration) and latch its addr, wdata, size, we and port id. Evaluate the error conditions, then go to ISSUE.
- **Error conditions:**
  - size = 11
  - half with addr[0] = 1
  - word with addr[1:0] ≠ 0
  - addr ≥ `MEM_BYTES`
- **ISSUE:**
  - Drive `daddr` = latched addr.
  - For a write, also drive `indata` and `stw` = size, and pulse `we` high for exactly this cycle.
  - For a read, drive `str` = size.
  - On error, drive nothing: `we` = 0 and all DMEM outputs stay 0.
  - Go to DONE.
- **DONE:**
  - Pulse the winner's ack.
  - `err` = latched error flag.
  - For a good read, register `outdata` into the winner's rdata. Writes and errors leave rdata unchanged.
  - Go to IDLE.
- DMEM outputs return to 0 in IDLE and DONE.
- A loser's request is not lost; it is served in a later IDLE.
- A requester deasserting `req` before ack is a protocol violation and is not checked; the latched access still completes.

## Timing
- Request sampled in IDLE at cycle 0: ISSUE at cycle 1, ack/err/rdata at cycle 2. Latency is 2 cycles, uniform for read, write and error.
- A new arbitration happens at the earliest at cycle 3, so the maximum rate is one access per 3 cycles.
- The same port may request again in the cycle after its ack, and it is sampled in that IDLE.
- All outputs reset to 0, including rdata and `busy`, and the FSM resets to IDLE.
- Reset mid-access:
  - `we` deasserts asynchronously.
  - No ack is issued.
  - The pending write may or may not have reached DMEM if the reset lands in ISSUE.
- The round-robin pointer resets to "last served = port 1", so port 0 wins the first tie.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin. On simultaneous requests, the port not served last wins. A single requester always wins.
- Not defined: fixed priority. Port 0 always wins ties, and port 1 can starve under continuous port 0 traffic.

## Test plan
- Port 0 writes word 0xDEADBEEF at 0x10, then reads 0x10: `we` high for one cycle in ISSUE with `stw` = 10. Read ack at cycle 2 with `p0_rdata` = 0xDEADBEEF and `p0_err` = 0.
- Both ports request continuously for 6 accesses:
  - With `DMEM_ARB_RR_EN`, ack order is 0,1,0,1,0,1.
  - Without it, all acks go to port 0 until it drops `req`.
- Misalignment: word at 0x02, half at 0x01, size 11 at 0x00, and word at `MEM_BYTES` → ack + err at cycle 2, `we` never asserted, rdata unchanged.
- Byte write 0xAB at 0x07 from port 1, then word read 0x04: `stw` = 00 and `str` = 10 are driven in the respective ISSUE cycles, and `p1_rdata` equals DMEM's `outdata`.
- Assert `rst_n` low during ISSUE of a write: `we` goes to 0 immediately, no ack, all outputs 0. After release, port 0 wins a simultaneous request.
